// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel_pkg.sv
// Shared types and bounds for the mux4 round-robin select sequencer.
package gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } rr_state_e;

    typedef logic [1:0] lane_t;

    localparam int unsigned HOLD_MIN = 32'd1;
    localparam int unsigned HOLD_MAX = 32'd16;

    function automatic logic [3:0] lane_onehot(input lane_t lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rr_pick4.sv
// Combinational round-robin picker: first set request after ptr, wrapping to ptr itself last.
module gf180mcu_fd_sc_mcu7t5v0__rr_pick4
    import gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel_pkg::*;
(
    input  logic [3:0] req,
    input  lane_t      ptr,
    output lane_t      lane,
    output logic       found
);

    // Scan from lowest priority to highest so the nearest lane after ptr wins.
    always_comb begin
        lane  = ptr;
        found = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (req[ptr + lane_t'(k)]) begin
                lane  = ptr + lane_t'(k);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel.sv
// Round-robin S1:S0 sequencer for the mux4 cell; grants are held up to HOLD cycles.
// Optional GF180MCU_FD_SC_MCU7T5V0__MUX4_RRSEL_PARK_EN keeps the last lane on the selects while idle.
module gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel
    import gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel_pkg::*;
#(
    parameter  int unsigned HOLD = 32'd4,
    localparam int unsigned CW   = $clog2(HOLD) + 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       ACK,
    output logic       S0,
    output logic       S1,
    output logic [3:0] GNT,
    output logic       VALID
);

    if ((HOLD < HOLD_MIN) || (HOLD > HOLD_MAX)) begin : g_hold_range
        $error("HOLD out of legal range");
    end

    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 32'd1);

    rr_state_e     state_q, state_d;
    lane_t         ptr_q, ptr_d;
    lane_t         lane_q, lane_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          valid_q, valid_d;

    logic [3:0] cur_mask;
    logic       lane_req;
    logic       release_lane;
    logic       grant_end;
    logic [3:0] pick_req;
    lane_t      pick_ptr;
    lane_t      pick_lane;
    logic       pick_found;

    assign cur_mask     = lane_onehot(lane_q);
    assign lane_req     = |(REQ & cur_mask);
    assign release_lane = ACK || !lane_req;
    assign grant_end    = (cnt_q == {CW{1'b0}}) || release_lane;

    // Arbitration inputs: from idle use the stored pointer; at grant end search after the current lane.
    always_comb begin
        pick_req = REQ;
        pick_ptr = ptr_q;
        case (state_q)
            ST_IDLE: begin
                pick_req = REQ;
                pick_ptr = ptr_q;
            end
            ST_GRANT: begin
                if (release_lane) begin
                    pick_req = REQ & ~cur_mask;
                end else begin
                    pick_req = REQ;
                end
                pick_ptr = lane_q;
            end
            default: begin
                pick_req = 4'b0000;
                pick_ptr = ptr_q;
            end
        endcase
    end

    gf180mcu_fd_sc_mcu7t5v0__rr_pick4 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .lane  (pick_lane),
        .found (pick_found)
    );

    // Next-state, hold counter and output register inputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    lane_d  = pick_lane;
                    gnt_d   = lane_onehot(pick_lane);
                    valid_d = 1'b1;
                    cnt_d   = CNT_LOAD;
                end else begin
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!grant_end) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ptr_d = lane_q;
                    if (pick_found) begin
                        lane_d  = pick_lane;
                        gnt_d   = lane_onehot(pick_lane);
                        valid_d = 1'b1;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                        cnt_d   = {CW{1'b0}};
`ifdef GF180MCU_FD_SC_MCU7T5V0__MUX4_RRSEL_PARK_EN
                        lane_d  = lane_q;
`else
                        lane_d  = 2'b00;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                lane_d  = 2'b00;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd3;
            lane_q  <= 2'd0;
            cnt_q   <= {CW{1'b0}};
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign S0    = lane_q[0];
    assign S1    = lane_q[1];
    assign GNT   = gnt_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel.sv
// Bench for the mux4 round-robin sequencer: three HOLD variants against a cycle model, plus vector tables.
module tb_gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel;

`ifdef GF180MCU_FD_SC_MCU7T5V0__MUX4_RRSEL_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] REQ;
    logic       ACK;
    logic [2:0] s0_w, s1_w, v_w;
    logic [3:0] g_w [3];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel #(.HOLD(4)) u_h4 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .ACK(ACK),
        .S0(s0_w[0]), .S1(s1_w[0]), .GNT(g_w[0]), .VALID(v_w[0]));
    gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel #(.HOLD(2)) u_h2 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .ACK(ACK),
        .S0(s0_w[1]), .S1(s1_w[1]), .GNT(g_w[1]), .VALID(v_w[1]));
    gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel #(.HOLD(1)) u_h1 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .ACK(ACK),
        .S0(s0_w[2]), .S1(s1_w[2]), .GNT(g_w[2]), .VALID(v_w[2]));

    // Reference model: "who holds the mux, for how many more cycles, and who went last".
    int hold_v [3] = '{4, 2, 1};
    bit m_valid [3];
    int m_lane  [3];
    int m_left  [3];
    int m_last  [3];

    function automatic int next_lane(input logic [3:0] mask, input int after);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(after + k) % 4]) return (after + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int i, input logic rst, input logic [3:0] req, input logic ack);
        logic [3:0] m;
        int nl;
        if (rst) begin
            m_valid[i] = 1'b0; m_lane[i] = 0; m_left[i] = 0; m_last[i] = 3;
        end else if (!m_valid[i]) begin
            nl = next_lane(req, m_last[i]);
            if (nl >= 0) begin
                m_valid[i] = 1'b1; m_lane[i] = nl; m_left[i] = hold_v[i] - 1;
            end
        end else if (m_left[i] > 0 && !ack && req[m_lane[i]]) begin
            m_left[i]--;
        end else begin
            m_last[i] = m_lane[i];
            m = req;
            if (ack || !req[m_lane[i]]) m[m_lane[i]] = 1'b0;
            nl = next_lane(m, m_last[i]);
            if (nl >= 0) begin
                m_lane[i] = nl; m_left[i] = hold_v[i] - 1;
            end else begin
                m_valid[i] = 1'b0; m_left[i] = 0;
                if (!PARK) m_lane[i] = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare every DUT #1 later.
    task automatic cyc(input logic rst, input logic [3:0] req, input logic ack);
        int exp_g;
        RST = rst; REQ = req; ACK = ack;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) model_step(i, rst, req, ack);
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_g = m_valid[i] ? (1 << m_lane[i]) : 0;
            chk($sformatf("model_valid_h%0d", hold_v[i]), int'(v_w[i]), int'(m_valid[i]));
            chk($sformatf("model_sel_h%0d", hold_v[i]), int'({s1_w[i], s0_w[i]}), m_lane[i]);
            chk($sformatf("model_gnt_h%0d", hold_v[i]), int'(g_w[i]), exp_g);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic       exp_v;
        logic [1:0] exp_lane;
    } vec_t;

    vec_t tbl[$];
    int   exp2 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [1:0] park_lane;
    logic [3:0] exp_gnt;
    logic [3:0] rq;

    initial begin
        RST = 1'b1; REQ = 4'b0000; ACK = 1'b0;
        park_lane = PARK ? 2'd1 : 2'd0;

        // HOLD=4 hand vectors: single requester, ACK alternation, REQ drop, reset mid-grant.
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0});
        for (int k = 0; k < 6; k++) tbl.push_back(vec_t'{1'b0, 4'b0001, 1'b0, 1'b1, 2'd0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0});
        tbl.push_back(vec_t'{1'b0, 4'b0101, 1'b0, 1'b1, 2'd0});
        tbl.push_back(vec_t'{1'b0, 4'b0101, 1'b1, 1'b1, 2'd2});
        tbl.push_back(vec_t'{1'b0, 4'b0101, 1'b1, 1'b1, 2'd0});
        tbl.push_back(vec_t'{1'b0, 4'b0101, 1'b1, 1'b1, 2'd2});
        tbl.push_back(vec_t'{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b0, 1'b0, park_lane});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b0, 1'b0, park_lane});
        tbl.push_back(vec_t'{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2});
        tbl.push_back(vec_t'{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2});
        tbl.push_back(vec_t'{1'b1, 4'b0100, 1'b0, 1'b0, 2'd0});
        tbl.push_back(vec_t'{1'b0, 4'b1100, 1'b0, 1'b1, 2'd2});
        tbl.push_back(vec_t'{1'b0, 4'b1100, 1'b0, 1'b1, 2'd2});

        foreach (tbl[n]) begin
            cyc(tbl[n].rst, tbl[n].req, tbl[n].ack);
            exp_gnt = tbl[n].exp_v ? (4'b0001 << tbl[n].exp_lane) : 4'b0000;
            chk($sformatf("tbl%0d_valid", n), int'(v_w[0]), int'(tbl[n].exp_v));
            chk($sformatf("tbl%0d_sel", n), int'({s1_w[0], s0_w[0]}), int'(tbl[n].exp_lane));
            chk($sformatf("tbl%0d_gnt", n), int'(g_w[0]), int'(exp_gnt));
        end

        // HOLD=2, all lanes requesting: two cycles per lane, no gap.
        cyc(1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 4'b1111, 1'b0);
            chk($sformatf("h2_rr%0d_valid", k), int'(v_w[1]), 1);
            chk($sformatf("h2_rr%0d_sel", k), int'({s1_w[1], s0_w[1]}), exp2[k]);
        end

        // HOLD=1 with ACK every cycle: exactly one switch per cycle.
        cyc(1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 4'b0011, 1'b1);
            chk($sformatf("h1_alt%0d_valid", k), int'(v_w[2]), 1);
            chk($sformatf("h1_alt%0d_sel", k), int'({s1_w[2], s0_w[2]}), k % 2);
        end

        // Random traffic against the model for all three HOLD values.
        cyc(1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 600; k++) begin
            rq = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 4'b0000;
            cyc(($urandom_range(0, 63) == 0), rq, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel.md
# gf180mcu_fd_sc_mcu7t5v0__mux4_rrsel

Round-robin select sequencer that drives the S0/S1 select inputs of the 7-track mux4 cell. It arbitrates among four requesting lanes, so the mux4 forwards I0..I3 to Z in time-division order. Each grant is held for a bounded number of cycles and can be released early. It sits directly upstream of the mux4 select pins and beside the lane sources that drive I0..I3.

## Interface
- HOLD, default 4: maximum cycles per grant; legal range 1..16.
- CW, default $clog2(HOLD)+1: hold-counter width; derived, never overridden.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; one clock, synchronous, active-high.
- REQ  in  4  per-lane request; bit k asserts that lane Ik has data to forward.
- ACK  in  1  consumer has taken the current lane; ends the grant early.
- S0   out 1  mux4 select bit 0, registered.
- S1   out 1  mux4 select bit 1, registered.
- GNT  out 4  one-hot grant, registered; equals the decode of S1:S0 when VALID=1, else 0.
- VALID out 1  a lane is granted, so mux4 Z is meaningful.

## Operation
- States: IDLE and GRANT. Internal PTR[1:0] holds the last granted lane. CNT[CW-1:0] holds the remaining hold cycles.
- Reset:
  - S0=S1=0, GNT=0, VALID=0, state=IDLE, CNT=0.
  - PTR=3, so the first grant goes to lane 0.
- Lane selection: pick the first set REQ bit in the order PTR+1, PTR+2, PTR+3, PTR (mod 4).
  - The previous lane is chosen again only if no other lane requests.
- IDLE: if REQ≠0, select a lane, then load:
  - S1:S0 = lane, GNT = one-hot(lane), VALID = 1
  - CNT = HOLD-1
  - next state = GRANT
- GRANT: the grant ends on any of these in a given cycle:
  - CNT==0
  - ACK==1
  - REQ[lane]==0
- Simultaneous end conditions are one end event.
- While the grant continues, CNT decrements by 1.
- On grant end, PTR is set to the current lane, then:
  - If REQ, with REQ[lane] masked when ACK=1 or REQ[lane]=0, is nonzero: re-arbitrate immediately and load the new lane. This is back-to-back with no VALID gap.
  - Otherwise: VALID=0, GNT=0, state=IDLE.
- When HOLD=1, CNT is always 0, so arbitration happens every cycle.
- RST asserted mid-grant returns everything to reset values at that edge. The in-flight grant is abandoned and PTR=3.

## Timing
- All outputs are registered; none depends combinationally on REQ or ACK.
- Request latency: REQ rising before edge n gives VALID/S high after edge n (one cycle).
- Grant length without ACK or REQ drop is exactly HOLD cycles.
- An ACK sampled at edge n moves S/GNT to the next lane, or sets VALID=0, after edge n.
- S0/S1 change only on CLK rising edges. The mux4 combinational path then settles within the same cycle.

## Configuration
- Macro: GF180MCU_FD_SC_MCU7T5V0__MUX4_RRSEL_PARK_EN.
- Defined: in IDLE, S1:S0 keep the last granted lane (park). This avoids select toggling on the mux4 between bursts.
- Undefined: on entry to IDLE, S1:S0 return to 00.
- In both cases GNT=0 and VALID=0 in IDLE, and reset values are unchanged.

## Structure
- A shared package holds:
  - state encoding (IDLE=1'b0, GRANT=1'b1)
  - the lane index type (2 bits)
  - the HOLD legality bounds (1, 16)
- One sub-module, gf180mcu_fd_sc_mcu7t5v0__rr_pick4: a combinational round-robin picker.
  - Inputs: REQ mask and PTR.
  - Outputs: lane and a found flag.
- The FSM, counter and output registers live in the top module.

## Test plan
- Reset then REQ=4'b0001, HOLD=4, no ACK: VALID=1, S1:S0=00 one cycle later, held 4 cycles, then continues re-granting lane 0 while REQ stays set.
- REQ=4'b1111, HOLD=2, no ACK: grants lanes 0,1,2,3,0, each for 2 cycles, with no VALID gap.
- REQ=4'b0101, ACK pulsed in each grant's first cycle: lanes alternate 0,2,0,2, one cycle each.
- Lane 1 granted, REQ drops to 0: VALID=0, GNT=0 next cycle; S1:S0 read 01 with PARK_EN and 00 without.
- RST asserted mid-grant on lane 2: all outputs at reset values after the edge; the next REQ=4'b1100 grants lane 2 first (PTR=3).
- HOLD=1, REQ=4'b0011 with ACK and CNT==0 coinciding: single switch per cycle, alternating 0,1.
